// File: rtl/axis_pkt_checker.sv
// AXI-S sink that parses the standard test packet format and checks tag/len/id/index/flow/order/keep.
// Latency: pkt_done/pkt_err and counters update one cycle after the tlast beat is accepted.
// Backpressure: s_rready is registered and driven by bp_mode (always, LFSR between packets, LFSR per cycle, hold).
module axis_pkt_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int FLOWS_W    = 3,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [DATA_WIDTH-1:0]         s_rdata,
    input  logic                          s_rvalid,
    output logic                          s_rready,
    input  logic                          s_rlast,
    input  logic [DATA_WIDTH/8-1:0]       s_rkeep,
    input  logic [1:0]                    bp_mode,
    input  logic                          clr,
    output logic                          pkt_done,
    output logic                          pkt_err,
    output logic [CNT_W-1:0]              pkt_count,
    output logic [CNT_W-1:0]              err_count,
    output logic [(2**FLOWS_W)*CNT_W-1:0] flow_count,
    output logic [5:0]                    err_status
);

    localparam int NF     = 2**FLOWS_W;
    localparam int E_TAG  = 0;
    localparam int E_LEN  = 1;
    localparam int E_ID   = 2;
    localparam int E_IDX  = 3;
    localparam int E_FLOW = 4;
    localparam int E_ORD  = 5;

    typedef enum logic [1:0] {HDR0, HDR1, PAYLOAD, DRAIN} state_t;

    state_t               state_q, state_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic                 rdy_q, rdy_d;
    logic [7:0]           len_q, len_d;
    logic [7:0]           id_q, id_d;
    logic [7:0]           idx_q, idx_d;
    logic [FLOWS_W-1:0]   flow_q, flow_d;
    logic [5:0]           perr_q, perr_d;
    logic                 done_q, done_d;
    logic                 perr_out_q, perr_out_d;
    logic [CNT_W-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]     err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]     flow_cnt_q [NF];
    logic [CNT_W-1:0]     flow_cnt_d [NF];
    logic [5:0]           err_status_q, err_status_d;
    logic [7:0]           last_id_q [NF];
    logic [7:0]           last_id_d [NF];
    logic [NF-1:0]        last_vld_q, last_vld_d;

    logic [31:0]          w;
    logic [7:0]           f_tag, f_len, f_id, f_lo;
    logic                 acc;
    logic                 complete;
    logic [5:0]           beat_err;
    logic [5:0]           all_err;
    logic [FLOWS_W-1:0]   cur_flow;
    logic [7:0]           id_diff;
    logic                 ord_bad;
    logic [7:0]           len_m1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign w     = s_rdata[31:0];
    assign f_tag = w[31:24];
    assign f_len = w[23:16];
    assign f_id  = w[15:8];
    assign f_lo  = w[7:0];

    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        rdy_d        = rdy_q;
        len_d        = len_q;
        id_d         = id_q;
        idx_d        = idx_q;
        flow_d       = flow_q;
        perr_d       = perr_q;
        done_d       = 1'b0;
        perr_out_d   = 1'b0;
        pkt_cnt_d    = pkt_cnt_q;
        err_cnt_d    = err_cnt_q;
        flow_cnt_d   = flow_cnt_q;
        err_status_d = err_status_q;
        last_id_d    = last_id_q;
        last_vld_d   = last_vld_q;
        complete     = 1'b0;
        beat_err     = '0;
        acc          = s_rvalid && rdy_q;
        len_m1       = len_q - 8'd1;

        // The flow field arrives on beat 1; later beats use the latched copy.
        cur_flow = (state_q == HDR1) ? w[FLOWS_W-1:0] : flow_q;
        id_diff  = id_q - last_id_q[cur_flow];
        ord_bad  = last_vld_q[cur_flow] && ((id_diff == 8'd0) || id_diff[7]);

        unique case (bp_mode)
            2'd0:    rdy_d = 1'b1;
            2'd1:    rdy_d = ((acc && s_rlast) || !rdy_q) ? lfsr_q[0] : 1'b1;
            2'd2:    rdy_d = lfsr_q[0];
            default: rdy_d = 1'b0;
        endcase

        if (acc) begin
            if (s_rkeep != {(DATA_WIDTH/8){1'b1}}) beat_err[E_ORD] = 1'b1;
            unique case (state_q)
                HDR0: begin
                    len_d = f_len;
                    id_d  = f_id;
                    if (f_tag != 8'h80) beat_err[E_TAG] = 1'b1;
                    if (f_lo != f_id)   beat_err[E_ID]  = 1'b1;
                    if (f_len < 8'd2 || s_rlast) beat_err[E_LEN] = 1'b1;
                    if (s_rlast) complete = 1'b1;
                    else         state_d  = HDR1;
                end
                HDR1: begin
                    flow_d = w[FLOWS_W-1:0];
                    idx_d  = 8'd2;
                    if (f_tag != 8'h40)              beat_err[E_TAG]  = 1'b1;
                    if (f_len != len_q)              beat_err[E_LEN]  = 1'b1;
                    if (f_id != id_q)                beat_err[E_ID]   = 1'b1;
                    if ((f_lo >> FLOWS_W) != 8'd0)   beat_err[E_FLOW] = 1'b1;
                    if (ord_bad)                     beat_err[E_ORD]  = 1'b1;
                    if (s_rlast) begin
                        complete = 1'b1;
                        state_d  = HDR0;
                        if (len_q != 8'd2) beat_err[E_LEN] = 1'b1;
                    end else if (len_q <= 8'd2) begin
                        // Beat 1 was the last legal beat (or len was already bad): skip to tlast.
                        beat_err[E_LEN] = 1'b1;
                        state_d         = DRAIN;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    idx_d = idx_q + 8'd1;
                    if (f_tag != 8'h2f) beat_err[E_TAG] = 1'b1;
                    if (f_len != len_q) beat_err[E_LEN] = 1'b1;
                    if (f_id != id_q)   beat_err[E_ID]  = 1'b1;
                    if (f_lo != idx_q)  beat_err[E_IDX] = 1'b1;
                    if (s_rlast) begin
                        complete = 1'b1;
                        state_d  = HDR0;
                        if (idx_q != len_m1) beat_err[E_LEN] = 1'b1;
                    end else if (idx_q == len_m1) begin
                        beat_err[E_LEN] = 1'b1;
                        state_d         = DRAIN;
                    end
                end
                default: begin
                    if (s_rlast) begin
                        complete = 1'b1;
                        state_d  = HDR0;
                    end
                end
            endcase
        end

        all_err = perr_q | beat_err;
        if (acc) perr_d = all_err;

        if (complete) begin
            perr_d       = '0;
            done_d       = 1'b1;
            perr_out_d   = |all_err;
            pkt_cnt_d    = sat_inc(pkt_cnt_q);
            err_status_d = err_status_q | all_err;
            if (|all_err) err_cnt_d = sat_inc(err_cnt_q);
            else          flow_cnt_d[cur_flow] = sat_inc(flow_cnt_q[cur_flow]);
            // A packet that ended on beat 0 never carried a flow, so history is left alone.
            if (state_q != HDR0 && !all_err[E_FLOW]) begin
                last_id_d[cur_flow]  = id_q;
                last_vld_d[cur_flow] = 1'b1;
            end
        end

        if (clr) begin
            done_d       = 1'b0;
            perr_out_d   = 1'b0;
            pkt_cnt_d    = '0;
            err_cnt_d    = '0;
            err_status_d = '0;
            last_vld_d   = '0;
            for (int f = 0; f < NF; f++) flow_cnt_d[f] = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= HDR0;
            lfsr_q       <= 16'hACE1;
            rdy_q        <= 1'b0;
            len_q        <= '0;
            id_q         <= '0;
            idx_q        <= '0;
            flow_q       <= '0;
            perr_q       <= '0;
            done_q       <= 1'b0;
            perr_out_q   <= 1'b0;
            pkt_cnt_q    <= '0;
            err_cnt_q    <= '0;
            err_status_q <= '0;
            last_vld_q   <= '0;
            for (int f = 0; f < NF; f++) begin
                flow_cnt_q[f] <= '0;
                last_id_q[f]  <= '0;
            end
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            rdy_q        <= rdy_d;
            len_q        <= len_d;
            id_q         <= id_d;
            idx_q        <= idx_d;
            flow_q       <= flow_d;
            perr_q       <= perr_d;
            done_q       <= done_d;
            perr_out_q   <= perr_out_d;
            pkt_cnt_q    <= pkt_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_status_q <= err_status_d;
            last_vld_q   <= last_vld_d;
            flow_cnt_q   <= flow_cnt_d;
            last_id_q    <= last_id_d;
        end
    end

    assign s_rready   = rdy_q;
    assign pkt_done   = done_q;
    assign pkt_err    = perr_out_q;
    assign pkt_count  = pkt_cnt_q;
    assign err_count  = err_cnt_q;
    assign err_status = err_status_q;

    for (genvar g = 0; g < NF; g++) begin : g_flow_out
        assign flow_count[g*CNT_W +: CNT_W] = flow_cnt_q[g];
    end

endmodule
